// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for a RISC-V core
// sharing one memory port between instruction fetch and load/store.
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instruction,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             bus_error,
    output logic             illegal_op
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_q;
    logic [7:0] wait_cnt;
    logic [6:0] opcode;
    logic       is_legal;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jump;
    logic       retire;
    logic       wait_expired;
    logic       unused_instr_bits;

    assign opcode            = instruction[6:0];
    assign unused_instr_bits = ^instruction[31:7];
    assign state             = state_q;
    assign wait_expired      = (wait_cnt == WAIT_LAST);

    always_comb begin
        is_legal  = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        case (opcode)
            OP_R, OP_IMM, OP_LUI, OP_AUIPC: is_legal = 1'b1;
            OP_LOAD:   begin is_legal = 1'b1; is_load   = 1'b1; end
            OP_STORE:  begin is_legal = 1'b1; is_store  = 1'b1; end
            OP_BRANCH: begin is_legal = 1'b1; is_branch = 1'b1; end
            OP_JAL, OP_JALR: begin is_legal = 1'b1; is_jump = 1'b1; end
            default: ;
        endcase
    end

    // NOTE: strobes are also gated by rst so nothing leaks out while the
    // asynchronous reset is held, even though state_q already reads FETCH.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_PLUS4;
        reg_write    = 1'b0;
        retire       = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    ir_write = mem_ready;
                end
                S_EXEC: begin
                    if (is_branch) begin
                        pc_write = 1'b1;
                        pc_src   = branch_taken ? PC_BRANCH : PC_PLUS4;
                        retire   = 1'b1;
                    end
                end
                S_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = is_store;
                    if (mem_ready && is_store) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end
                end
                S_WB: begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    retire    = 1'b1;
                    pc_src    = is_jump ? PC_JUMP : PC_PLUS4;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_FETCH;
            retired    <= '0;
            bus_error  <= 1'b0;
            illegal_op <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            if (retire) begin
                retired <= retired + CNT_W'(1);
            end
            case (state_q)
                S_FETCH: begin
                    if (mem_ready) begin
                        state_q <= S_DECODE;
                    end else if (wait_expired) begin
                        bus_error <= 1'b1;
                        state_q   <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    if (!is_legal) begin
                        illegal_op <= 1'b1;
                        state_q    <= S_HALT;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_load || is_store) begin
                        wait_cnt <= '0;
                        state_q  <= S_MEM;
                    end else if (is_branch) begin
                        wait_cnt <= '0;
                        state_q  <= S_FETCH;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    // mem_ready on the last allowed cycle still completes normally
                    if (mem_ready) begin
                        wait_cnt <= '0;
                        state_q  <= is_store ? S_FETCH : S_WB;
                    end else if (wait_expired) begin
                        bus_error <= 1'b1;
                        state_q   <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_WB: begin
                    wait_cnt <= '0;
                    state_q  <= S_FETCH;
                end
                S_HALT: ;
                default: state_q <= S_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: per-cycle expected strobes are
// queued from a spec-level trace builder and compared as the DUT steps.
module tb_multicycle_sequencer;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [31:0]      instruction = 32'd0;
    logic             branch_taken = 1'b0;
    logic             mem_ready = 1'b0;
    logic             mem_req;
    logic             mem_we;
    logic             mem_addr_sel;
    logic             ir_write;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             reg_write;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;
    logic             bus_error;
    logic             illegal_op;

    multicycle_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr_sel(mem_addr_sel), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .reg_write(reg_write), .state(state), .retired(retired),
        .bus_error(bus_error), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       st;
        logic             rdy;
        logic             bt;
        logic             req;
        logic             we;
        logic             sel;
        logic             irw;
        logic             pcw;
        logic [1:0]       src;
        logic             rw;
        logic             bus;
        logic             ill;
        logic [CNT_W-1:0] ret;
    } cyc_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        bt;
        int          fw;
        int          mw;
        int          cycles;
        logic [1:0]  src;
        logic        rw;
    } vec_t;

    cyc_t             sb_q[$];
    vec_t             vecs[12];
    int               checks = 0;
    int               failures = 0;
    logic             exp_bus = 1'b0;
    logic             exp_ill = 1'b0;
    logic [CNT_W-1:0] exp_ret = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] pack_dut();
        return {15'd0, state, mem_req, mem_we, mem_addr_sel, ir_write, pc_write,
                pc_src, reg_write, bus_error, illegal_op, retired};
    endfunction

    function automatic logic [31:0] pack_exp(input cyc_t c);
        return {15'd0, c.st, c.req, c.we, c.sel, c.irw, c.pcw,
                c.src, c.rw, c.bus, c.ill, c.ret};
    endfunction

    task automatic push(input logic [2:0] st, input logic rdy, input logic bt,
                        input logic req, input logic we, input logic sel,
                        input logic irw, input logic pcw, input logic [1:0] src,
                        input logic rw, input logic retire);
        cyc_t c;
        c.st = st; c.rdy = rdy; c.bt = bt; c.req = req; c.we = we; c.sel = sel;
        c.irw = irw; c.pcw = pcw; c.src = src; c.rw = rw;
        c.bus = exp_bus; c.ill = exp_ill; c.ret = exp_ret;
        sb_q.push_back(c);
        if (retire) exp_ret = exp_ret + 1'b1;
    endtask

    // Expected per-cycle behaviour of one legal instruction, from the opcode.
    task automatic build_trace(input logic [31:0] instr, input logic bt, input int fw, input int mw);
        logic [6:0] op;
        logic is_br, is_ld, is_st, is_j;
        op    = instr[6:0];
        is_br = (op == 7'b1100011);
        is_ld = (op == 7'b0000011);
        is_st = (op == 7'b0100011);
        is_j  = (op == 7'b1101111) || (op == 7'b1100111);
        for (int i = 0; i < fw; i++) push(3'd0, 1'b0, bt, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        push(3'd0, 1'b1, bt, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        push(3'd1, 1'b1, bt, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        push(3'd2, 1'b1, bt, 1'b0, 1'b0, 1'b0, 1'b0, is_br, (is_br && bt) ? 2'b01 : 2'b00, 1'b0, is_br);
        if (is_ld || is_st) begin
            for (int i = 0; i < mw; i++) push(3'd3, 1'b0, bt, 1'b1, is_st, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
            push(3'd3, 1'b1, bt, 1'b1, is_st, 1'b1, 1'b0, is_st, 2'b00, 1'b0, is_st);
        end
        if (!is_br && !is_st) push(3'd4, 1'b1, bt, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, is_j ? 2'b10 : 2'b00, 1'b1, 1'b1);
    endtask

    // Entered and left at a falling edge; one queued record per clock.
    task automatic run_queue(input string tag, output int first_pcw, output logic [1:0] pcw_src,
                             output logic rw_seen);
        cyc_t c;
        int cyc;
        cyc = 0; first_pcw = -1; pcw_src = 2'b00; rw_seen = 1'b0;
        while (sb_q.size() > 0) begin
            c = sb_q.pop_front();
            mem_ready = c.rdy;
            branch_taken = c.bt;
            #1;
            check($sformatf("%s cyc%0d", tag, cyc), pack_dut(), pack_exp(c));
            if (pc_write && first_pcw < 0) begin
                first_pcw = cyc;
                pcw_src = pc_src;
            end
            if (reg_write) rw_seen = 1'b1;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int first;
        logic [1:0] src;
        logic rw;
        instruction = v.instr;
        build_trace(v.instr, v.bt, v.fw, v.mw);
        run_queue(v.name, first, src, rw);
        check({v.name, " latency"}, 32'(first + 1), 32'(v.cycles));
        check({v.name, " pc_src"}, 32'(src), 32'(v.src));
        check({v.name, " reg_write"}, 32'(rw), 32'(v.rw));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b1;
        branch_taken = 1'b1;
        #1;
        check("reset immediate", pack_dut(), 32'd0);
        @(negedge clk);
        #1;
        check("reset held", pack_dut(), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_ret = '0;
        exp_bus = 1'b0;
        exp_ill = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        logic [1:0] src;
        logic rw;

        vecs[0]  = '{"ADD",      32'h002081B3, 1'b0, 0,  0, 4,  2'b00, 1'b1};
        vecs[1]  = '{"LW wait3", 32'h0000A183, 1'b0, 0,  3, 8,  2'b00, 1'b1};
        vecs[2]  = '{"BEQ taken",32'h00208463, 1'b1, 0,  0, 3,  2'b01, 1'b0};
        vecs[3]  = '{"BNE not",  32'h00209463, 1'b0, 0,  0, 3,  2'b00, 1'b0};
        vecs[4]  = '{"SW",       32'h0030A023, 1'b0, 0,  0, 4,  2'b00, 1'b0};
        vecs[5]  = '{"JAL",      32'h0000006F, 1'b0, 0,  0, 4,  2'b10, 1'b1};
        vecs[6]  = '{"JALR",     32'h00008067, 1'b0, 0,  0, 4,  2'b10, 1'b1};
        vecs[7]  = '{"LUI",      32'h000012B7, 1'b0, 0,  0, 4,  2'b00, 1'b1};
        vecs[8]  = '{"AUIPC fw2",32'h00001297, 1'b0, 2,  0, 6,  2'b00, 1'b1};
        vecs[9]  = '{"ADDI",     32'h00108093, 1'b0, 0,  0, 4,  2'b00, 1'b1};
        vecs[10] = '{"SW wait2", 32'h0030A023, 1'b0, 0,  2, 6,  2'b00, 1'b0};
        vecs[11] = '{"ADD fw14", 32'h002081B3, 1'b0, 14, 0, 18, 2'b00, 1'b1};

        @(negedge clk);
        do_reset();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Fetch timeout: 15 waiting cycles, then HALT with bus_error; HALT ignores inputs.
        instruction = vecs[0].instr;
        for (int i = 0; i < MEM_TIMEOUT; i++)
            push(3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        exp_bus = 1'b1;
        for (int i = 0; i < 3; i++)
            push(3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        run_queue("timeout", first, src, rw);
        do_reset();

        // Illegal opcode: HALT with illegal_op, strobes stay low until reset.
        instruction = 32'h0000000F;
        push(3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        push(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        exp_ill = 1'b1;
        for (int i = 0; i < 3; i++)
            push(3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        run_queue("illegal", first, src, rw);
        do_reset();

        // Counter wrap: 15 retires reach all-ones, the 16th wraps to 0, the 17th gives 1.
        for (int i = 0; i < 17; i++) run_vec(vecs[9]);

        // Reset during a STORE memory wait: strobes drop at once, no partial retire.
        instruction = vecs[4].instr;
        push(3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        push(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        push(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        push(3'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        run_queue("sw reset", first, src, rw);
        mem_ready = 1'b0;
        #1;
        check("sw reset mem_we before", 32'(mem_we), 32'd1);
        check("sw reset retired before", 32'(retired), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("sw reset outputs after", pack_dut(), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_ret = '0;
        exp_bus = 1'b0;
        exp_ill = 1'b0;
        run_vec(vecs[0]);
        push(3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        run_queue("final fetch", first, src, rw);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
